// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch controller. Addresses a combinational
//            instruction memory, captures the returned word into an
//            instruction register and hands it to decode over valid/ready.
//            Handles start, decode back-pressure, branch redirects and a
//            HALT opcode, and counts instructions accepted by decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                   WORD_SIZE  = 8,
    parameter int                   INDEX_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HALT_OP    = 8'hFF,
    parameter int                   CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_SIZE-1:0]  ins_val,
    output logic [INDEX_SIZE-1:0] prog_count,
    output logic [WORD_SIZE-1:0]  ir_out,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  branch_en,
    input  logic [INDEX_SIZE-1:0] branch_target,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FETCH  = 2'd1;
    localparam logic [1:0] c_ST_STALL  = 2'd2;
    localparam logic [1:0] c_ST_HALTED = 2'd3;

    logic [1:0]            r_state;
    logic [INDEX_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0]  r_ir;
    logic                  r_ir_valid;
    logic                  r_halted;
    logic [CNT_WIDTH-1:0]  r_fetch_count;

    logic                  w_accept;
    logic                  w_slot_free;

    // Handshake qualifiers: a word is delivered this cycle, or the register
    // can take a new word at the next edge.
    always_comb begin
        w_accept    = r_ir_valid & ir_ready;
        w_slot_free = ~r_ir_valid | ir_ready;
    end

    // Saturating count of instructions delivered to decode, in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_accept && !(&r_fetch_count)) begin
            r_fetch_count <= r_fetch_count + 1'b1;
        end
    end

    // Fetch state machine: pc, instruction register, valid flag and halt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Branches are meaningless before fetch starts.
                    if (start) begin
                        r_state <= c_ST_FETCH;
                    end
                end
                c_ST_FETCH: begin
                    if (branch_en) begin
                        r_pc       <= branch_target;
                        r_ir_valid <= 1'b0;
                    end else if (w_slot_free) begin
                        r_ir       <= ins_val;
                        r_ir_valid <= 1'b1;
                        if (ins_val == HALT_OP) begin
                            r_halted <= 1'b1;
                            r_state  <= c_ST_HALTED;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end else begin
                        r_state <= c_ST_STALL;
                    end
                end
                c_ST_STALL: begin
                    // The held word leaves on accept; the register is empty
                    // for one cycle and fetch resumes on the following edge.
                    if (branch_en) begin
                        r_pc       <= branch_target;
                        r_ir_valid <= 1'b0;
                        r_state    <= c_ST_FETCH;
                    end else if (w_accept) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= c_ST_FETCH;
                    end
                end
                c_ST_HALTED: begin
                    // The HALT word drains to decode; only reset leaves here.
                    if (w_accept) begin
                        r_ir_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign prog_count  = r_pc;
    assign ir_out      = r_ir;
    assign ir_valid    = r_ir_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire
